// File: rtl/clock_display_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clock_display_scan_pkg
//  Purpose  : Shared constants for the clock display scanner. This covers the
//             active-low 7-segment glyphs (gfedcba), the blank and dash codes,
//             the digit count, the time snapshot type and the anode decode
//             helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package clock_display_scan_pkg;

    localparam int NUM_DIGITS = 6;

    // Glyphs are gfedcba, active-low (0 = segment lit)
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One frame's worth of time, captured together so the frame never tears
    typedef struct packed {
        logic       pm;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } time_snap_t;

    // Active-low one-hot anode for the given digit index
    function automatic logic [5:0] anode_n(input logic [2:0] digit);
        return ~(6'b000001 << digit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_display_scan_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clock_display_scan_if
//  Purpose  : Bundles the time inputs from clock_main, the blank control and
//             the anode/segment pad outputs of the display scanner.
//  Ports    : pm, hh, mm, ss, blank (toward scanner); an, seg (from scanner)
//             master = time source / pad side, slave = scanner
//  Revision : 1.0 - initial release
// ============================================================================
interface clock_display_scan_if;
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       blank;
    logic [5:0] an;
    logic [7:0] seg;

    modport master (output pm, hh, mm, ss, blank, input  an, seg);
    modport slave  (input  pm, hh, mm, ss, blank, output an, seg);
endinterface
`default_nettype wire

// File: rtl/clock_display_scan_bcd_to_seg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clock_display_scan_bcd_to_seg
//  Purpose  : Combinational BCD nibble to active-low 7-segment glyph. Any
//             nibble above 9 shows a dash (g segment only).
//  Ports    : nibble_i [3:0] BCD digit
//             glyph_o  [6:0] gfedcba, active-low
//  Revision : 1.0 - initial release
// ============================================================================
module clock_display_scan_bcd_to_seg
    import clock_display_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_DASH;
        case (nibble_i)
            4'd0:    glyph_o = SEG_0;
            4'd1:    glyph_o = SEG_1;
            4'd2:    glyph_o = SEG_2;
            4'd3:    glyph_o = SEG_3;
            4'd4:    glyph_o = SEG_4;
            4'd5:    glyph_o = SEG_5;
            4'd6:    glyph_o = SEG_6;
            4'd7:    glyph_o = SEG_7;
            4'd8:    glyph_o = SEG_8;
            4'd9:    glyph_o = SEG_9;
            default: glyph_o = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/clock_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clock_display_scan
//  Purpose  : Time-multiplexes six 7-segment digits (HH.MM.SS) from a
//             per-frame snapshot of clock_main's BCD time. The segment and
//             anode drive is active-low and registered.
//  Ports    : clk   - system clock
//             reset - synchronous, active-low
//             disp  - slave modport: pm/hh/mm/ss/blank in, an/seg out
//  Params   : REFRESH_DIV - clk cycles each digit is held (>= 2)
//  Revision : 1.0 - initial release
// ============================================================================
module clock_display_scan
    import clock_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_display_scan_if.slave  disp
);

    localparam int               TICK_W     = $clog2(REFRESH_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick_q,   tick_d;
    logic [2:0]        digit_q,  digit_d;
    time_snap_t        shadow_q, shadow_d;
    logic [5:0]        an_q,     an_d;
    logic [7:0]        seg_q,    seg_d;

    logic       frame_start;
    logic       tick_wrap;
    logic [3:0] nibble;
    logic [6:0] glyph;
    logic       dp_lit;

    assign frame_start = (tick_q == '0) && (digit_q == 3'd0);
    assign tick_wrap   = (tick_q == TICK_LAST);

    // Prescaler and digit counter
    always_comb begin
        tick_d  = tick_wrap ? '0 : tick_q + 1'b1;
        digit_d = digit_q;
        if (tick_wrap) begin
            digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
        end
    end

    // Output uses the value being captured on the frame-start cycle, so digit 0
    // already shows the new frame's snapshot rather than the previous one.
    assign shadow_d = frame_start ? '{pm: disp.pm, hh: disp.hh, mm: disp.mm, ss: disp.ss}
                                  : shadow_q;

    always_comb begin
        nibble = 4'd0;
        case (digit_q)
            3'd5:    nibble = shadow_d.hh[7:4];
            3'd4:    nibble = shadow_d.hh[3:0];
            3'd3:    nibble = shadow_d.mm[7:4];
            3'd2:    nibble = shadow_d.mm[3:0];
            3'd1:    nibble = shadow_d.ss[7:4];
            default: nibble = shadow_d.ss[3:0];
        endcase
    end

    clock_display_scan_bcd_to_seg u_bcd_to_seg (
        .nibble_i (nibble),
        .glyph_o  (glyph)
    );

    // Separators after hours and minutes; rightmost dp doubles as PM indicator
    always_comb begin
        dp_lit = (digit_q == 3'd4) || (digit_q == 3'd2) ||
                 ((digit_q == 3'd0) && shadow_d.pm);
        seg_d  = {~dp_lit, glyph};
        if ((digit_q == 3'd5) && (nibble == 4'd0)) begin
            seg_d = SEG_BLANK;  // leading-zero suppression on hours tens
        end
        an_d = disp.blank ? 6'h3F : anode_n(digit_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q   <= '0;
            digit_q  <= 3'd0;
            shadow_q <= '0;
            an_q     <= 6'h3F;
            seg_q    <= SEG_BLANK;
        end else begin
            tick_q   <= tick_d;
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;

endmodule
`default_nettype wire
